ad7476_spi_master: RTL and testbench

AD7476_SPI_MASTER -- requirements
Module: ad7476_spi_master

---
 rtl/ad7476_spi_master.sv | 195 +++++++++++++++++++
 tb/tb_ad7476_spi_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad7476_spi_master.sv
// rtl/ad7476_spi_master.sv - AD7476 SPI master: periodic trigger, 16-bit frame capture, valid/ready result.
// Optional leading-zero frame check enabled by defining ADC_LEADZERO_CHK_EN.
module ad7476_spi_master #(
   parameter int CLK_DIV  = 2,
   parameter int CS_SETUP = 4,
   parameter int QUIET    = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        enable_i,
   input  logic [15:0] sample_period_i,
   input  logic        clr_ovr_i,
   output logic        adc_csn_o,
   output logic        adc_sclk_o,
   input  logic        adc_sdata_i,
   output logic [11:0] sample_o,
   output logic        sample_valid_o,
   input  logic        sample_ready_i,
   output logic        overrun_o,
   output logic        frame_err_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_QUIET} state_t;

   localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
   localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
   localparam logic [3:0] QUIET_LAST = 4'(QUIET - 1);
`ifdef ADC_LEADZERO_CHK_EN
   localparam int SR_W = 16;
`else
   localparam int SR_W = 12;
`endif

   state_t          state_q, state_d;
   logic [15:0]     per_cnt_q, per_cnt_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [4:0]      hp_q, hp_d;
   logic            csn_q, csn_d;
   logic            sclk_q, sclk_d;
   logic [SR_W-1:0] sr_q, sr_d;
   logic [11:0]     sample_q, sample_d;
   logic            valid_q, valid_d;
   logic            ovr_q, ovr_d;
   logic [15:0]     period_last;
   logic            trig;
   logic            capture;
   logic            frame_done;
   logic            load_sample;

   // A period of 0 behaves as 1: trigger on every enabled clock.
   always_comb begin
      period_last = (sample_period_i == 16'd0) ? 16'd0 : sample_period_i - 16'd1;
      trig        = enable_i && (per_cnt_q == period_last);
      per_cnt_d   = 16'd0;
      if (enable_i && !trig) begin
         per_cnt_d = per_cnt_q + 16'd1;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hp_d       = hp_q;
      csn_d      = csn_q;
      sclk_d     = sclk_q;
      capture    = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (trig) begin
               state_d = ST_SETUP;
               csn_d   = 1'b0;
               cnt_d   = 4'd0;
            end
         end
         ST_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = ST_SHIFT;
               sclk_d  = 1'b0;
               capture = 1'b1;
               cnt_d   = 4'd0;
               hp_d    = 5'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_SHIFT: begin
            // Entry already made the first fall; 31 further toggles end on a rise.
            if (cnt_q == DIV_LAST) begin
               cnt_d = 4'd0;
               if (hp_q == 5'd31) begin
                  state_d    = ST_QUIET;
                  csn_d      = 1'b1;
                  frame_done = 1'b1;
               end else begin
                  hp_d    = hp_q + 5'd1;
                  sclk_d  = !sclk_q;
                  capture = sclk_q;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_QUIET: begin
            if (cnt_q == QUIET_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sr_d        = sr_q;
      sample_d    = sample_q;
      valid_d     = valid_q;
      ovr_d       = ovr_q;
      load_sample = frame_done && (!valid_q || sample_ready_i);
      if (capture) begin
         sr_d = {sr_q[SR_W-2:0], adc_sdata_i};
      end
      if (load_sample) begin
         sample_d = sr_q[11:0];
         valid_d  = 1'b1;
      end else if (valid_q && sample_ready_i) begin
         valid_d = 1'b0;
      end
      if ((trig && (state_q != ST_IDLE)) || (frame_done && valid_q && !sample_ready_i)) begin
         ovr_d = 1'b1;
      end else if (clr_ovr_i) begin
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         per_cnt_q <= 16'd0;
         cnt_q     <= 4'd0;
         hp_q      <= 5'd0;
         csn_q     <= 1'b1;
         sclk_q    <= 1'b1;
         sr_q      <= '0;
         sample_q  <= 12'd0;
         valid_q   <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         per_cnt_q <= per_cnt_d;
         cnt_q     <= cnt_d;
         hp_q      <= hp_d;
         csn_q     <= csn_d;
         sclk_q    <= sclk_d;
         sr_q      <= sr_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         ovr_q     <= ovr_d;
      end
   end

`ifdef ADC_LEADZERO_CHK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (load_sample) begin
         err_d = |sr_q[15:12];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign frame_err_o = err_q;
`else
   assign frame_err_o = 1'b0;
`endif

   assign adc_csn_o      = csn_q;
   assign adc_sclk_o     = sclk_q;
   assign sample_o       = sample_q;
   assign sample_valid_o = valid_q;
   assign overrun_o      = ovr_q;
   assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ad7476_spi_master.sv
// tb/tb_ad7476_spi_master.sv - self-checking bench for ad7476_spi_master
module tb_ad7476_spi_master;

   localparam int CS_SETUP = 4;
   localparam int CLK_DIV  = 2;
   localparam int LOW_CLKS = CS_SETUP + 32 * CLK_DIV;
`ifdef ADC_LEADZERO_CHK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] period = 16'd0;
   logic        clr_ovr = 1'b0;
   logic        ready = 1'b0;
   logic        csn, sclk, sdata, valid, ovr, ferr, busy;
   logic [11:0] sample;

   always #5 clk = ~clk;

   ad7476_spi_master dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .enable_i        (enable),
      .sample_period_i (period),
      .clr_ovr_i       (clr_ovr),
      .adc_csn_o       (csn),
      .adc_sclk_o      (sclk),
      .adc_sdata_i     (sdata),
      .sample_o        (sample),
      .sample_valid_o  (valid),
      .sample_ready_i  (ready),
      .overrun_o       (ovr),
      .frame_err_o     (ferr),
      .busy_o          (busy)
   );

   // ADC model: presents bit (15 - falls so far) of the word latched at CSn fall.
   logic [15:0] adc_word = 16'h0000;
   logic [15:0] cur_word = 16'h0000;
   logic [4:0]  bitpos   = 5'd16;
   always @(negedge csn) begin
      cur_word = adc_word;
      bitpos   = 5'd0;
   end
   always @(negedge sclk) if (!csn && bitpos < 5'd16) bitpos = bitpos + 5'd1;
   assign sdata = (bitpos < 5'd16) ? cur_word[4'd15 - bitpos[3:0]] : 1'b0;

   int          low_cnt = 0, falls = 0, setup_cnt = 0, valid_cnt = 0, rises = 0;
   int          stab_err = 0, idle_sclk_err = 0;
   logic [11:0] got_sample = 12'd0;
   logic        got_err = 1'b0;
   logic        p_sclk = 1'b1, p_csn = 1'b1, p_valid = 1'b0;
   logic [11:0] p_sample = 12'd0;

   always @(negedge clk) begin
      if (!csn) begin
         low_cnt++;
         if (p_sclk && !sclk) falls++;
         if (falls == 0 && sclk) setup_cnt++;
      end else if (!sclk) begin
         idle_sclk_err++;
      end
      if (!p_csn && csn) rises++;
      if (valid) begin
         valid_cnt++;
         got_sample = sample;
         got_err    = ferr;
      end
      if (p_valid && !ready && (!valid || sample != p_sample)) stab_err++;
      p_sclk   = sclk;
      p_csn    = csn;
      p_valid  = valid;
      p_sample = sample;
   end

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_stats();
      low_cnt = 0; falls = 0; setup_cnt = 0; valid_cnt = 0; rises = 0;
      stab_err = 0; idle_sclk_err = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; clr_ovr = 1'b0; ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   function automatic int ref_latency(input logic [15:0] p);
      return (p == 16'd0) ? 1 : int'(p);
   endfunction
   function automatic logic [11:0] ref_sample(input logic [15:0] w);
      return w[11:0];
   endfunction
   function automatic logic ref_err(input logic [15:0] w);
      return LZ && (w[15:12] != 4'h0);
   endfunction

   typedef struct {
      logic [15:0] period;
      logic [15:0] word;
      int          rdy_delay;
      logic [11:0] exp_sample;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   localparam int NVEC = 12;
   vec_t vecs [NVEC];

   task automatic run_vec(input vec_t v, input int idx);
      int    n;
      string t;
      t = $sformatf("v%0d", idx);
      clear_stats();
      adc_word = v.word;
      period   = v.period;
      ready    = (v.rdy_delay == 0);
      enable   = 1'b1;
      n = 0;
      while (csn && n < v.exp_lat + 10) begin tick(); n++; end
      chk({t, ".trig_lat"}, 32'(n), 32'(v.exp_lat));
      enable = 1'b0;
      n = 0;
      while (!valid && n < 200) begin tick(); n++; end
      chk({t, ".valid_seen"}, 32'(valid), 32'd1);
      chk({t, ".csn_high_at_valid"}, 32'(csn), 32'd1);
      for (int i = 0; i < v.rdy_delay; i++) begin
         tick();
         chk({t, ".valid_hold"}, 32'(valid), 32'd1);
      end
      ready = 1'b1;
      tick();
      chk({t, ".valid_clr"}, 32'(valid), 32'd0);
      ready = 1'b0;
      n = 0;
      while (busy && n < 20) begin tick(); n++; end
      chk({t, ".idle"}, 32'(busy), 32'd0);
      chk({t, ".csn_low_clks"}, 32'(low_cnt), 32'(LOW_CLKS));
      chk({t, ".sclk_falls"}, 32'(falls), 32'd16);
      chk({t, ".setup_clks"}, 32'(setup_cnt), 32'(CS_SETUP));
      chk({t, ".valid_clks"}, 32'(valid_cnt), 32'(v.rdy_delay + 1));
      chk({t, ".sample"}, 32'(got_sample), 32'(v.exp_sample));
      chk({t, ".frame_err"}, 32'(got_err), 32'(v.exp_err));
      chk({t, ".overrun"}, 32'(ovr), 32'd0);
      chk({t, ".stable"}, 32'(stab_err), 32'd0);
      chk({t, ".sclk_idle_high"}, 32'(idle_sclk_err), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      vec_t r;
      vecs[0] = '{16'd200, 16'h0AA5, 0, 12'hAA5, 1'b0, 200};
      vecs[1] = '{16'd80,  16'h0FFF, 0, 12'hFFF, 1'b0, 80};
      vecs[2] = '{16'd73,  16'h0000, 2, 12'h000, 1'b0, 73};
      vecs[3] = '{16'd0,   16'h0555, 1, 12'h555, 1'b0, 1};
      vecs[4] = '{16'd1,   16'h0ABC, 0, 12'hABC, 1'b0, 1};
      vecs[5] = '{16'd150, 16'h8AA5, 0, 12'hAA5, LZ,   150};
      for (int i = 6; i < NVEC; i++) begin
         r.period     = 16'(73 + $urandom_range(0, 120));
         r.word       = 16'($urandom);
         r.rdy_delay  = int'($urandom_range(0, 3));
         r.exp_sample = ref_sample(r.word);
         r.exp_err    = ref_err(r.word);
         r.exp_lat    = ref_latency(r.period);
         vecs[i] = r;
      end

      rst = 1'b1;
      tick(); tick();
      chk("rst.csn", 32'(csn), 32'd1);
      chk("rst.sclk", 32'(sclk), 32'd1);
      chk("rst.sample", 32'(sample), 32'd0);
      chk("rst.valid", 32'(valid), 32'd0);
      chk("rst.overrun", 32'(ovr), 32'd0);
      chk("rst.frame_err", 32'(ferr), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

      // Period 40 is shorter than a 72-clock frame: triggers at 80 and 160 are dropped.
      do_reset();
      clear_stats();
      period = 16'd40; ready = 1'b1; adc_word = 16'h0123; enable = 1'b1;
      for (int e = 1; e <= 79; e++) tick();
      chk("ovr.before", 32'(ovr), 32'd0);
      clr_ovr = 1'b1;
      tick();
      chk("ovr.set_beats_clr", 32'(ovr), 32'd1);
      tick();
      clr_ovr = 1'b0;
      chk("ovr.clr", 32'(ovr), 32'd0);
      n = 0;
      while (!ovr && n < 80) begin tick(); n++; end
      chk("ovr.within_2_periods", 32'(ovr), 32'd1);
      chk("ovr.sample_delivered", 32'(got_sample), 32'h123);
      enable = 1'b0;
      n = 0;
      while (busy && n < 200) begin tick(); n++; end
      chk("ovr.sticky", 32'(ovr), 32'd1);
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      chk("ovr.clr_disabled", 32'(ovr), 32'd0);
      tick();
      chk("ovr.stays_clr", 32'(ovr), 32'd0);

      // Consumer stalls across two frames: second result is discarded.
      do_reset();
      clear_stats();
      period = 16'd100; ready = 1'b0; adc_word = 16'h0AA5; enable = 1'b1;
      n = 0;
      while (csn && n < 110) begin tick(); n++; end
      adc_word = 16'h0AA6;
      n = 0;
      while (rises < 1 && n < 200) begin tick(); n++; end
      chk("stall.first_valid", 32'(valid), 32'd1);
      chk("stall.first_sample", 32'(sample), 32'hAA5);
      chk("stall.no_ovr_yet", 32'(ovr), 32'd0);
      n = 0;
      while (rises < 2 && n < 300) begin tick(); n++; end
      chk("stall.second_frame", 32'(rises), 32'd2);
      chk("stall.sample_kept", 32'(sample), 32'hAA5);
      chk("stall.valid_kept", 32'(valid), 32'd1);
      chk("stall.overrun", 32'(ovr), 32'd1);
      enable = 1'b0; ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("stall.valid_clr", 32'(valid), 32'd0);
      chk("stall.stable", 32'(stab_err), 32'd0);
      n = 0;
      while (busy && n < 100) begin tick(); n++; end

      // Reset lands mid-frame after the 8th SCLK fall.
      do_reset();
      clear_stats();
      period = 16'd50; ready = 1'b1; adc_word = 16'h0AA5; enable = 1'b1;
      n = 0;
      while (falls < 8 && n < 200) begin tick(); n++; end
      chk("midrst.falls", 32'(falls), 32'd8);
      rst = 1'b1; enable = 1'b0;
      tick();
      rst = 1'b0;
      chk("midrst.csn", 32'(csn), 32'd1);
      chk("midrst.sclk", 32'(sclk), 32'd1);
      chk("midrst.busy", 32'(busy), 32'd0);
      chk("midrst.valid", 32'(valid), 32'd0);
      for (int i = 0; i < 100; i++) tick();
      chk("midrst.no_sample", 32'(valid_cnt), 32'd0);
      chk("midrst.overrun", 32'(ovr), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
